// File: rtl/inst_cache.sv
// Direct-mapped, read-only instruction cache between fetcher and memctrl.
// One-word lines; hits answer one cycle after the request, misses refill one word.
module inst_cache #(
    parameter int INDEX_W = 8,
    parameter int TAG_W   = 30 - INDEX_W
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        clr,
    input  logic        iINF_en,
    input  logic [31:0] iINF_pc,
    output logic        oINF_en,
    output logic [31:0] oINF_inst,
    output logic        oMC_en,
    output logic [31:0] oMC_pc,
    input  logic        iMC_done,
    input  logic [31:0] iMC_inst
);

    localparam int LINES = 1 << INDEX_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MISS = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t state;

    logic [LINES-1:0] valid_q;
    logic [TAG_W-1:0] tag_arr  [LINES];
    logic [31:0]      data_arr [LINES];

    logic [INDEX_W-1:0] req_idx;
    logic [TAG_W-1:0]   req_tag;
    logic [INDEX_W-1:0] fill_idx;
    logic [TAG_W-1:0]   fill_tag;
    logic               hit;
    logic               accept;
    logic               fill_we;
    logic               unused_pc_lsb;

    assign req_idx  = iINF_pc[INDEX_W+1:2];
    assign req_tag  = iINF_pc[31:INDEX_W+2];
    // The latched miss address lives in oMC_pc and stays put through DROP.
    assign fill_idx = oMC_pc[INDEX_W+1:2];
    assign fill_tag = oMC_pc[31:INDEX_W+2];

    assign hit     = valid_q[req_idx] && (tag_arr[req_idx] == req_tag);
    assign accept  = iINF_en && !oINF_en && !clr;
    assign fill_we = rdy && iMC_done && (state == MISS || state == DROP);

    assign unused_pc_lsb = ^iINF_pc[1:0];

    // Tag and data storage carry no reset; valid bits gate every use.
    always_ff @(posedge clk) begin
        if (fill_we) begin
            tag_arr[fill_idx]  <= fill_tag;
            data_arr[fill_idx] <= iMC_inst;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            valid_q   <= '0;
            oINF_en   <= 1'b0;
            oINF_inst <= 32'h0;
            oMC_en    <= 1'b0;
            oMC_pc    <= 32'h0;
        end else if (rdy) begin
            oINF_en <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        if (hit) begin
                            oINF_en   <= 1'b1;
                            oINF_inst <= data_arr[req_idx];
                        end else begin
                            oMC_en <= 1'b1;
                            oMC_pc <= iINF_pc;
                            state  <= MISS;
                        end
                    end
                end
                MISS: begin
                    if (iMC_done) begin
                        valid_q[fill_idx] <= 1'b1;
                        oMC_en            <= 1'b0;
                        state             <= IDLE;
                        if (!clr) begin
                            oINF_en   <= 1'b1;
                            oINF_inst <= iMC_inst;
                        end
                    end else if (clr) begin
                        oMC_en <= 1'b0;
                        state  <= DROP;
                    end
                end
                // Flushed miss: the word is still right for its address, keep it.
                DROP: begin
                    if (iMC_done) begin
                        valid_q[fill_idx] <= 1'b1;
                        state             <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inst_cache.sv
// Directed bench for inst_cache: scoreboard queue of expected instructions,
// immediate assertions at each comparison point.
module tb_inst_cache;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        clr;
    logic        iINF_en;
    logic [31:0] iINF_pc;
    logic        oINF_en;
    logic [31:0] oINF_inst;
    logic        oMC_en;
    logic [31:0] oMC_pc;
    logic        iMC_done;
    logic [31:0] iMC_inst;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_q[$];

    inst_cache dut (
        .clk      (clk),
        .rst      (rst),
        .rdy      (rdy),
        .clr      (clr),
        .iINF_en  (iINF_en),
        .iINF_pc  (iINF_pc),
        .oINF_en  (oINF_en),
        .oINF_inst(oINF_inst),
        .oMC_en   (oMC_en),
        .oMC_pc   (oMC_pc),
        .iMC_done (iMC_done),
        .iMC_inst (iMC_inst)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_resp(input string tag);
        logic [31:0] exp;
        int n;
        n = 0;
        while (oINF_en !== 1'b1 && n < 8) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_en"}, {31'h0, oINF_en}, 32'h1);
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
        check({tag, "_inst"}, oINF_inst, exp);
    endtask

    task automatic miss_fill(input string tag, input logic [31:0] pc,
                             input logic [31:0] data);
        @(negedge clk);
        iINF_en = 1'b1;
        iINF_pc = pc;
        @(negedge clk);
        check({tag, "_mc_en"}, {31'h0, oMC_en}, 32'h1);
        check({tag, "_mc_pc"}, oMC_pc, pc);
        @(negedge clk);
        iMC_done = 1'b1;
        iMC_inst = data;
        exp_q.push_back(data);
        @(negedge clk);
        iMC_done = 1'b0;
        wait_resp(tag);
        iINF_en = 1'b0;
        check({tag, "_mc_off"}, {31'h0, oMC_en}, 32'h0);
    endtask

    task automatic hit(input string tag, input logic [31:0] pc,
                       input logic [31:0] data);
        @(negedge clk);
        iINF_en = 1'b1;
        iINF_pc = pc;
        exp_q.push_back(data);
        @(negedge clk);
        check({tag, "_no_mc"}, {31'h0, oMC_en}, 32'h0);
        wait_resp(tag);
        iINF_en = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        rdy      = 1'b1;
        clr      = 1'b0;
        iINF_en  = 1'b0;
        iINF_pc  = 32'h0;
        iMC_done = 1'b0;
        iMC_inst = 32'h0;

        @(negedge clk);
        check("rst_inf_en", {31'h0, oINF_en}, 32'h0);
        check("rst_inf_inst", oINF_inst, 32'h0);
        check("rst_mc_en", {31'h0, oMC_en}, 32'h0);
        check("rst_mc_pc", oMC_pc, 32'h0);
        rst = 1'b0;

        // Cold miss then hit
        miss_fill("cold", 32'h0000_0004, 32'h0050_0093);
        hit("rehit", 32'h0000_0004, 32'h0050_0093);

        // Done while idle is ignored
        @(negedge clk);
        iMC_done = 1'b1;
        iMC_inst = 32'hdead_beef;
        @(negedge clk);
        iMC_done = 1'b0;
        check("idle_done_no_resp", {31'h0, oINF_en}, 32'h0);
        hit("idle_done_hit", 32'h0000_0004, 32'h0050_0093);

        // Conflict eviction on index 1
        miss_fill("evict", 32'h0000_0404, 32'h0000_0013);
        hit("evict_hit", 32'h0000_0404, 32'h0000_0013);
        miss_fill("refetch", 32'h0000_0004, 32'h0050_0093);

        // Flush in IDLE blocks acceptance for that cycle
        @(negedge clk);
        iINF_en = 1'b1;
        iINF_pc = 32'h0000_0004;
        clr     = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("clr_idle_no_resp", {31'h0, oINF_en}, 32'h0);
        check("clr_idle_no_mc", {31'h0, oMC_en}, 32'h0);
        exp_q.push_back(32'h0050_0093);
        @(negedge clk);
        wait_resp("clr_idle_late");
        iINF_en = 1'b0;

        // Flush during miss
        @(negedge clk);
        iINF_en = 1'b1;
        iINF_pc = 32'h0000_0100;
        @(negedge clk);
        check("flush_mc_en", {31'h0, oMC_en}, 32'h1);
        @(negedge clk);
        @(negedge clk);
        clr     = 1'b1;
        iINF_en = 1'b0;
        @(negedge clk);
        clr = 1'b0;
        check("flush_mc_drop", {31'h0, oMC_en}, 32'h0);
        check("flush_no_resp0", {31'h0, oINF_en}, 32'h0);
        @(negedge clk);
        iMC_done = 1'b1;
        iMC_inst = 32'h00a0_0113;
        @(negedge clk);
        iMC_done = 1'b0;
        check("flush_no_resp1", {31'h0, oINF_en}, 32'h0);
        @(negedge clk);
        check("flush_no_resp2", {31'h0, oINF_en}, 32'h0);
        hit("flush_hit", 32'h0000_0100, 32'h00a0_0113);

        // Flush coincident with done
        @(negedge clk);
        iINF_en = 1'b1;
        iINF_pc = 32'h0000_0200;
        @(negedge clk);
        check("coin_mc_en", {31'h0, oMC_en}, 32'h1);
        iMC_done = 1'b1;
        iMC_inst = 32'h0010_0193;
        clr      = 1'b1;
        iINF_en  = 1'b0;
        @(negedge clk);
        iMC_done = 1'b0;
        clr      = 1'b0;
        check("coin_no_resp", {31'h0, oINF_en}, 32'h0);
        check("coin_mc_off", {31'h0, oMC_en}, 32'h0);
        hit("coin_hit", 32'h0000_0200, 32'h0010_0193);

        // Stall during miss with a done pulse that must be ignored
        @(negedge clk);
        iINF_en = 1'b1;
        iINF_pc = 32'h0000_0300;
        @(negedge clk);
        check("stall_mc_en", {31'h0, oMC_en}, 32'h1);
        rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            iMC_done = (i == 2);
            iMC_inst = 32'hbad0_0000 | i;
            @(negedge clk);
            check("stall_hold_mc_en", {31'h0, oMC_en}, 32'h1);
            check("stall_hold_mc_pc", oMC_pc, 32'h0000_0300);
            check("stall_hold_no_resp", {31'h0, oINF_en}, 32'h0);
        end
        iMC_done = 1'b0;
        rdy      = 1'b1;
        @(negedge clk);
        check("stall_no_fill", {31'h0, oINF_en}, 32'h0);
        check("stall_still_miss", {31'h0, oMC_en}, 32'h1);
        iMC_done = 1'b1;
        iMC_inst = 32'h0020_0213;
        exp_q.push_back(32'h0020_0213);
        @(negedge clk);
        iMC_done = 1'b0;
        wait_resp("stall_done");
        iINF_en = 1'b0;
        hit("stall_hit", 32'h0000_0300, 32'h0020_0213);

        // Reset mid-miss
        @(negedge clk);
        iINF_en = 1'b1;
        iINF_pc = 32'h0000_0508;
        @(negedge clk);
        check("rmiss_mc_en", {31'h0, oMC_en}, 32'h1);
        #2 rst = 1'b1;
        #1;
        check("rmiss_mc_off", {31'h0, oMC_en}, 32'h0);
        check("rmiss_no_resp", {31'h0, oINF_en}, 32'h0);
        @(negedge clk);
        rst     = 1'b0;
        iINF_en = 1'b0;
        miss_fill("post_rst", 32'h0000_0004, 32'h0050_0093);

        check("queue_empty", exp_q.size(), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/inst_cache.md
# inst_cache

Direct-mapped, read-only instruction cache between the fetcher and the memory controller in the RV32I core. It serves 32-bit instruction fetches on hits one cycle after the request. On a miss it issues a single word fetch to memctrl, fills the line and forwards the instruction. It honours the pipeline flush (`clr`) and the global stall (`rdy`).

## Interface
Parameters:
- `INDEX_W`, default 8. Index bits; the cache holds 2^INDEX_W one-word lines (256 × 32 b by default).
- `TAG_W`, default `30-INDEX_W`. Tag width, equal to pc[31:INDEX_W+2].

Ports:
- `clk`  in  1  System clock. Single clock domain; all state changes on the rising edge.
- `rst`  in  1  Asynchronous, active-high reset.
- `rdy`  in  1  Global ready. When low, all state and outputs freeze.
- `clr`  in  1  Pipeline flush from the ROB, one-cycle pulse.
- `iINF_en`  in  1  Fetcher request valid (level, held until served).
- `iINF_pc`  in  32  Fetch address; bits [1:0] are always 0.
- `oINF_en`  out  1  Response valid, one-cycle pulse.
- `oINF_inst`  out  32  Instruction for the served request.
- `oMC_en`  out  1  Fetch request to memctrl, held until `iMC_done`.
- `oMC_pc`  out  32  Word address for memctrl, stable while `oMC_en` is high.
- `iMC_done`  in  1  memctrl fetch complete, one-cycle pulse.
- `iMC_inst`  in  32  Fetched word, valid with `iMC_done`.

## Operation
- Per line: `valid`, `tag[TAG_W]`, `data[32]`. Address fields: index = pc[INDEX_W+1:2], tag = pc[31:INDEX_W+2].
- FSM states: IDLE, MISS, DROP.
  - IDLE:
    - Accept a request when `iINF_en`=1, `oINF_en`=0 and `clr`=0.
    - Hit (valid and tag match): assert `oINF_en`, drive `oINF_inst`=data, stay in IDLE.
    - Miss: latch pc, set `oMC_en`=1 and `oMC_pc`=pc, go to MISS.
  - MISS: wait for `iMC_done`. On done, write the line (valid=1, tag, data=`iMC_inst`), pulse `oINF_en` with `oINF_inst`=`iMC_inst`, clear `oMC_en`, go to IDLE.
  - DROP: entered from MISS when `clr`=1 and no `iMC_done` arrives in that cycle. `oMC_en` drops at the same edge. Wait for `iMC_done`, fill the line (the data is still correct for the latched address), do not pulse `oINF_en`, then go to IDLE.
- Simultaneous events:
  - `clr` and `iMC_done` in the same cycle while in MISS: fill the line, suppress `oINF_en`, go to IDLE.
  - `clr` high in IDLE: no request is accepted that cycle.
  - `iMC_done` while in IDLE: ignored, no array write.
- `clr` never invalidates lines. Memory is treated as instruction-immutable; self-modifying code is unsupported.
- Back-to-back hits are served at one every two cycles, because the acceptance rule requires `oINF_en`=0.
- When `rdy`=0, nothing updates: FSM, arrays and output registers all hold, and a pending `iMC_done` is not sampled.

## Timing
- Reset, applied asynchronously:
  - All `valid` bits are cleared and the FSM goes to IDLE.
  - `oINF_en`=0, `oINF_inst`=0, `oMC_en`=0, `oMC_pc`=0.
  - Tag and data arrays are not reset.
- Hit latency: request sampled at edge T, `oINF_en` high during cycle T+1.
- Miss: `oMC_en` is high from T+1. `iMC_done` arrives at edge D, and `oINF_en` is high during cycle D+1.
- `iINF_pc` must stay stable while `iINF_en`=1 until `oINF_en` is seen. A pc change takes effect only through `clr`.
- Reset during MISS or DROP returns the FSM to IDLE immediately. memctrl is reset by the same `rst`, so no stale `iMC_done` follows.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- **Cold miss then hit:** after reset, request pc=0x0000_0004. Expect `oMC_en`=1 with `oMC_pc`=0x4. Return `iMC_done` with 0x0050_0093. Expect `oINF_en`=1 with `oINF_inst`=0x0050_0093 one cycle later. Re-request 0x4: expect `oINF_en` one cycle later and `oMC_en` staying 0.
- **Conflict eviction (INDEX_W=8):** fill 0x004, then request 0x404. Expect a miss and a fill with 0x0000_0013. Re-request 0x004: expect a miss again.
- **Flush during miss:** `clr` two cycles after `oMC_en` rises. Expect `oMC_en` to drop next edge and no `oINF_en` when `iMC_done` comes. A later request to the same pc hits.
- **Flush coincident with done:** `clr` and `iMC_done` in the same cycle. Expect no `oINF_en`, FSM in IDLE, line valid.
- **Stall:** hold `rdy`=0 for 5 cycles during MISS while pulsing `iMC_done`. Expect no fill, all outputs held. Repeat `iMC_done` after `rdy`=1: expect normal completion.
- **Reset mid-miss:** assert `rst` in MISS. Expect `oMC_en`=0 and `oINF_en`=0 immediately. A previously cached pc now misses.
